// File: rtl/mul_r4_seq_pkg.sv
// Shared definitions for the radix-4 sequential multiplier: FSM state encodings.
package mul_r4_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mul_r4_seq_if.sv
// Operation request/response bundle for mul_r4_seq; master issues operands, slave returns results.
interface mul_r4_seq_if #(
    parameter int WIDTH = 16
);
    logic                 iStart;
    logic                 iSigned;
    logic [WIDTH-1:0]     iA;
    logic [WIDTH-1:0]     iB;
    logic                 oBusy;
    logic                 oDone;
    logic [2*WIDTH-1:0]   oProduct;
    logic                 oHiSig;

    modport master (
        output iStart, iSigned, iA, iB,
        input  oBusy, oDone, oProduct, oHiSig
    );

    modport slave (
        input  iStart, iSigned, iA, iB,
        output oBusy, oDone, oProduct, oHiSig
    );
endinterface

// File: rtl/mul_r4_digit_sel.sv
// Radix-4 digit multiple: maps a 2-bit digit to {0, B, 2B, 3B} without losing the 3B carry.
module mul_r4_digit_sel #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       i_digit,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH+1:0] o_mult
);
    logic [WIDTH+1:0] w_b1;
    logic [WIDTH+1:0] w_b2;

    assign w_b1 = {2'b00, i_mcand};
    assign w_b2 = {1'b0, i_mcand, 1'b0};

    always_comb begin
        o_mult = '0;
        case (i_digit)
            2'd0:    o_mult = '0;
            2'd1:    o_mult = w_b1;
            2'd2:    o_mult = w_b2;
            default: o_mult = w_b1 + w_b2;
        endcase
    end
endmodule

// File: rtl/mul_r4_seq.sv
// Sequential radix-4 multiplier: magnitude shift-add over WIDTH/2 cycles, sign fix-up on the last digit.
module mul_r4_seq
    import mul_r4_seq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SIGNED_EN = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic                 iSigned,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oProduct,
    output logic                 oHiSig
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF + 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sign;
    logic                 r_smode;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_hisig;

    logic                 w_smode;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH+1:0]     w_mult;
    logic [CW-1:0]        w_k;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_result;
    logic                 w_hisig;

    assign w_smode = (SIGNED_EN != 0) && iSigned;
    assign w_mag_a = (w_smode && iA[WIDTH-1]) ? -iA : iA;
    assign w_mag_b = (w_smode && iB[WIDTH-1]) ? -iB : iB;

    // r_a is consumed two bits per cycle from the LSB end; r_b is the fixed multiple source.
    mul_r4_digit_sel #(.WIDTH(WIDTH)) u_digit_sel (
        .i_digit (r_a[1:0]),
        .i_mcand (r_b),
        .o_mult  (w_mult)
    );

    assign w_k      = CW'(HALF) - r_cnt;
    assign w_addend = {{(WIDTH-2){1'b0}}, w_mult} << {w_k, 1'b0};
    assign w_sum    = r_acc + w_addend;
    assign w_result = r_sign ? -w_sum : w_sum;
    assign w_hisig  = r_smode ? (w_result[2*WIDTH-1:WIDTH] != {WIDTH{w_result[WIDTH-1]}})
                              : (w_result[2*WIDTH-1:WIDTH] != '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_smode   <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_hisig   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_sign  <= w_smode && (iA[WIDTH-1] ^ iB[WIDTH-1]);
                        r_smode <= w_smode;
                        r_acc   <= '0;
                        r_cnt   <= CW'(HALF);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_sum;
                    r_a   <= r_a >> 2;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_product <= w_result;
                        r_hisig   <= w_hisig;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oBusy    = (r_state != ST_IDLE);
    assign oDone    = (r_state == ST_DONE);
    assign oProduct = r_product;
    assign oHiSig   = r_hisig;
endmodule
